vga_timing_pipe: RTL



---
 rtl/vga_timing_pipe_pkg.sv | 39 +++
 rtl/vga_delay_line.sv | 49 ++++
 rtl/vga_timing_pipe.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pipe_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe_pkg
// Shared constants and types for the VGA timing / pin pipeline.
//   - Default 640x480 timing, colour width and sync polarity.
//   - N_POLY: pixel-core polynomial length, carried over untouched from the
//     original top level so existing users keep compiling.
//   - timing_flags_t: per-pixel flags travelling down the alignment pipe.
//   - sync_level(): maps a raw sync flag to the pin level for a polarity.
// ---------------------------------------------------------------------------
package vga_timing_pipe_pkg;

    localparam int unsigned DEF_WCOLOR   = 6;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_SYNC_POL = 0;   // 0 = active-low syncs
    localparam int unsigned N_POLY       = 16;

    localparam int unsigned COORD_W   = 10;     // col/row counter width
    localparam int unsigned MAX_TOTAL = 1024;   // largest total a counter holds
    localparam int unsigned BAR_W     = 3;      // colour-bar index width

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } timing_flags_t;

    // Pin level is the active level when raw=1, its inverse otherwise.
    function automatic logic sync_level(input logic raw, input logic pol);
        return ~(raw ^ pol);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Parametrised shift register (WIDTH bits, DEPTH stages) with a shift enable
// and a synchronous clear. DEPTH=0 is a plain wire.
// Ports:
//   clk    in  clock
//   en_i   in  advance all stages by one
//   clr_i  in  synchronous clear of every stage (wins over en_i)
//   d_i    in  WIDTH  data into stage 0
//   q_o    out WIDTH  data out of the last stage
// ---------------------------------------------------------------------------
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
            // Control inputs have no effect without storage.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, en_i, clr_i};
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (clr_i) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage_q[i] <= '0;
                    end
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe
// Configurable VGA timing generator with a sync/blank alignment pipeline and
// a blank-gated, registered colour output stage.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   defined   -> test_mode port exists; test_mode=1 replaces pixel_in with
//                colour bars indexed by the delayed col[9:7].
//   undefined -> pixel_out is sourced only from pixel_in.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   col          out  10      current column, 0..H_TOTAL-1
//   row          out  10      current row, 0..V_TOTAL-1
//   pix_tick     out  1       high on clk cycles where coordinates advance
//   test_mode    in   1       (VGA_TEST_PATTERN_EN only) colour-bar select
//   pixel_in     in   WCOLOR  colour from pixel core, PIPE_DEPTH ticks late
//   pixel_out    out  WCOLOR  registered, blank-gated colour
//   h_sync       out  1       registered, aligned to pixel_out
//   v_sync       out  1       registered, aligned to pixel_out
//   blank        out  1       1 outside the active area, aligned to pixel_out
//   cmd_en       out  1       vblank command window, combinational from row
//   frame_start  out  1       one-clk pulse on the tick entering col=0,row=0
// ---------------------------------------------------------------------------
module vga_timing_pipe
    import vga_timing_pipe_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned SYNC_POL   = DEF_SYNC_POL,
    parameter int unsigned WCOLOR     = DEF_WCOLOR,
    parameter int unsigned PIPE_DEPTH = 1,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned CMD_GUARD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [9:0]        col,
    output logic [9:0]        row,
    output logic              pix_tick,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    input  logic [WCOLOR-1:0] pixel_in,
    output logic [WCOLOR-1:0] pixel_out,
    output logic              h_sync,
    output logic              v_sync,
    output logic              blank,
    output logic              cmd_en,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Boundaries are held one bit wider than the counters so totals of
    // exactly 1024 compare correctly.
    localparam logic [10:0] H_ACT_C   = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_C   = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] CMD_END   = 11'(V_TOTAL - CMD_GUARD);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [1:0]  DIV_LAST  = 2'(CLK_DIV - 1);
    localparam logic        SYNC_ACT  = (SYNC_POL != 0);

    localparam int unsigned FLAG_W = $bits(timing_flags_t);
`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DL_W = FLAG_W + BAR_W;
`else
    localparam int unsigned DL_W = FLAG_W;
`endif

    // ---------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------------
    generate
        if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
            $error("vga_timing_pipe: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
            $error("vga_timing_pipe: V_TOTAL exceeds 1024");
        end
        if (PIPE_DEPTH > 7) begin : g_bad_depth
            $error("vga_timing_pipe: PIPE_DEPTH must be 0..7");
        end
        if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
            $error("vga_timing_pipe: CLK_DIV must be 1..4");
        end
        if (CMD_GUARD > V_TOTAL) begin : g_bad_guard
            $error("vga_timing_pipe: CMD_GUARD exceeds V_TOTAL");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Pixel tick divider and coordinate counters
    // ---------------------------------------------------------------------
    logic [1:0] div_q, div_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       frame_start_q;
    logic       tick;
    logic       col_last;
    logic       row_last;

    assign tick     = (div_q == DIV_LAST);
    assign col_last = (col_q == H_LAST);
    assign row_last = (row_q == V_LAST);

    always_comb begin
        div_d = tick ? 2'd0 : div_q + 2'd1;
        col_d = col_q;
        row_d = row_q;
        if (tick) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? 10'd0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            row_q         <= row_d;
            // Only a counter wrap raises this; a reset to 0,0 does not.
            frame_start_q <= tick & col_last & row_last;
        end
    end

    // ---------------------------------------------------------------------
    // Raw timing flags from the current coordinates
    // ---------------------------------------------------------------------
    logic [10:0]   col_ext;
    logic [10:0]   row_ext;
    timing_flags_t raw_flags;

    assign col_ext = {1'b0, col_q};
    assign row_ext = {1'b0, row_q};

    always_comb begin
        raw_flags.hs     = (col_ext >= HS_BEGIN) && (col_ext < HS_END);
        raw_flags.vs     = (row_ext >= VS_BEGIN) && (row_ext < VS_END);
        raw_flags.active = (col_ext < H_ACT_C) && (row_ext < V_ACT_C);
    end

    // Command window depends on the row only, so it leads the pins.
    assign cmd_en = (row_ext >= V_ACT_C) && (row_ext < CMD_END);

    // ---------------------------------------------------------------------
    // Alignment pipeline: matches the pixel core latency
    // ---------------------------------------------------------------------
    logic [DL_W-1:0] dl_in;
    logic [DL_W-1:0] dl_out;
    timing_flags_t   dly_flags;

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in = {col_q[9:7], raw_flags};
`else
    assign dl_in = raw_flags;
`endif

    vga_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIPE_DEPTH)
    ) u_delay (
        .clk   (clk),
        .en_i  (tick),
        .clr_i (rst),
        .d_i   (dl_in),
        .q_o   (dl_out)
    );

    assign dly_flags = timing_flags_t'(dl_out[FLAG_W-1:0]);

    // ---------------------------------------------------------------------
    // Colour source selection
    // ---------------------------------------------------------------------
    logic [WCOLOR-1:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
    logic [BAR_W-1:0]  bar_idx;
    logic [WCOLOR-1:0] bar_rgb;

    assign bar_idx = dl_out[DL_W-1:FLAG_W];

    // Each index bit is doubled: {b2,b2,b1,b1,b0,b0}. Bits above the six
    // bar bits are zero; narrower colour buses keep the low bits.
    genvar gi;
    generate
        for (gi = 0; gi < int'(WCOLOR); gi++) begin : g_bar
            if (gi < 2 * int'(BAR_W)) begin : g_bit
                assign bar_rgb[gi] = bar_idx[gi/2];
            end else begin : g_zero
                assign bar_rgb[gi] = 1'b0;
            end
        end
    endgenerate

    assign pix_src = test_mode ? bar_rgb : pixel_in;
`else
    assign pix_src = pixel_in;
`endif

    // ---------------------------------------------------------------------
    // Output register stage
    // ---------------------------------------------------------------------
    logic [WCOLOR-1:0] pixel_q, pixel_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              blank_q, blank_d;

    always_comb begin
        pixel_d = dly_flags.active ? pix_src : '0;
        hs_d    = sync_level(dly_flags.hs, SYNC_ACT);
        vs_d    = sync_level(dly_flags.vs, SYNC_ACT);
        blank_d = ~dly_flags.active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_q <= '0;
            hs_q    <= ~SYNC_ACT;
            vs_q    <= ~SYNC_ACT;
            blank_q <= 1'b1;
        end else if (tick) begin
            pixel_q <= pixel_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign pix_tick    = tick;
    assign pixel_out   = pixel_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule
